// File: rtl/store_subword_rmw.sv
// Store unit for a word-only data memory: word stores write directly, byte and
// halfword stores read-modify-write. Optional build macro: STORE_MISALIGN_TRAP_EN.
module store_subword_rmw #(
  parameter int bADDR = 32
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [bADDR-1:0] ReqAddr,
  input  logic [31:0]      ReqData,
  input  logic [1:0]       ReqSize,
  output logic [bADDR-1:0] MemAddr,
  output logic             MemRead,
  input  logic [31:0]      MemRData,
  input  logic             MemRValid,
  output logic             MemWrite,
  output logic [31:0]      MemWData,
  output logic             Done,
  output logic             MisalignErr,
  output logic [1:0]       DbgState
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
`ifdef STORE_MISALIGN_TRAP_EN
  localparam logic [1:0] S_ERR   = 2'd3;
`endif

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Request handshake: a request transfers on a rising Clk edge where
  // ReqValid && ReqReady. ReqReady is high only in IDLE, so nothing is taken
  // while busy and a waiting requester simply holds ReqValid and its fields.
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [bADDR-1:0] r_addr;
  logic [31:0]      r_data;
  logic [1:0]       r_size;
  logic [31:0]      r_wdata;
  logic [31:0]      w_merged;
  logic             w_accept;
  logic             w_word;
  logic             w_capture;

  assign w_accept  = ReqValid & ReqReady;
  // Size 11 lands on the word path when trapping is disabled.
  assign w_word    = ReqSize[1];
  assign w_capture = (r_state == S_READ) & MemRValid;

`ifdef STORE_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((ReqSize == SZ_HALF) &  ReqAddr[0])
                    | ((ReqSize == SZ_WORD) & (ReqAddr[1:0] != 2'b00))
                    |  (ReqSize == 2'b11);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (ReqValid) begin
`ifdef STORE_MISALIGN_TRAP_EN
          if (w_misalign)  w_state_nxt = S_ERR;
          else if (w_word) w_state_nxt = S_WRITE;
          else             w_state_nxt = S_READ;
`else
          if (w_word) w_state_nxt = S_WRITE;
          else        w_state_nxt = S_READ;
`endif
        end
      end
      S_READ: begin
        if (MemRValid) w_state_nxt = S_WRITE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Overlay the registered store data onto the word returned by memory.
  always_comb begin
    w_merged = MemRData;
    case (r_size)
      SZ_BYTE: begin
        case (r_addr[1:0])
          2'd0:    w_merged[7:0]   = r_data[7:0];
          2'd1:    w_merged[15:8]  = r_data[7:0];
          2'd2:    w_merged[23:16] = r_data[7:0];
          default: w_merged[31:24] = r_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (r_addr[1]) w_merged[31:16] = r_data[15:0];
        else           w_merged[15:0]  = r_data[15:0];
      end
      default: w_merged = r_data;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= ReqAddr;
        r_data <= ReqData;
        r_size <= ReqSize;
        if (w_word) r_wdata <= ReqData;
      end
      if (w_capture) r_wdata <= w_merged;
    end
  end

  assign ReqReady = (r_state == S_IDLE);
  assign MemRead  = (r_state == S_READ);
  assign MemWrite = (r_state == S_WRITE);
  assign Done     = (r_state == S_WRITE);
  assign MemAddr  = {r_addr[bADDR-1:2], 2'b00};
  assign MemWData = r_wdata;
  assign DbgState = r_state;

`ifdef STORE_MISALIGN_TRAP_EN
  assign MisalignErr = (r_state == S_ERR);
`else
  assign MisalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_store_subword_rmw.sv
// Bench for store_subword_rmw: a bench-side memory plus a merge model predict
// every written word; a per-cycle compare process checks the control timeline.
module tb_store_subword_rmw;

  localparam int W      = 64;
  localparam int K_WORD = 0;
  localparam int K_SUB  = 1;
  localparam int K_ERR  = 2;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [31:0] ReqAddr = '0;
  logic [31:0] ReqData = '0;
  logic [1:0]  ReqSize = '0;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic [31:0] MemRData = '0;
  logic        MemRValid = 1'b0;
  logic        MemWrite;
  logic [31:0] MemWData;
  logic        Done;
  logic        MisalignErr;
  logic [1:0]  dbg_state;

  always #5 Clk = ~Clk;

  store_subword_rmw #(.bADDR(32)) dut (
    .Clk(Clk), .nReset(nReset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqSize(ReqSize),
    .MemAddr(MemAddr), .MemRead(MemRead),
    .MemRData(MemRData), .MemRValid(MemRValid),
    .MemWrite(MemWrite), .MemWData(MemWData),
    .Done(Done), .MisalignErr(MisalignErr), .DbgState(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e_item;
  logic [31:0]  mem [logic [31:0]];

  logic        chk_en = 1'b0;
  logic        e_ready = 1'b1;
  logic        e_read = 1'b0;
  logic        e_write = 1'b0;
  logic        e_err = 1'b0;
  logic        e_addr_en = 1'b0;
  logic [31:0] e_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_exp(input logic rdy, input logic rd, input logic wr, input logic er);
    e_ready = rdy;
    e_read  = rd;
    e_write = wr;
    e_err   = er;
  endtask

  // Word the memory must hold after the store, from the lane rules alone.
  function automatic logic [31:0] merge_model(input logic [31:0] old, input logic [31:0] a,
                                              input logic [31:0] d, input logic [1:0] sz);
    int sh;
    logic [31:0] m;
    if (sz == 2'b00) begin
      sh = 8 * int'(a[1:0]);
      m  = 32'hFF << sh;
    end else if (sz == 2'b01) begin
      sh = a[1] ? 16 : 0;
      m  = 32'hFFFF << sh;
    end else begin
      return d;
    end
    return (old & ~m) | ((d << sh) & m);
  endfunction

  function automatic int classify(input logic [31:0] a, input logic [1:0] sz);
`ifdef STORE_MISALIGN_TRAP_EN
    if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) return K_ERR;
`else
    if (a[31]) return K_SUB;
`endif
    return sz[1] ? K_WORD : K_SUB;
  endfunction

  // Compare process: every cycle the outputs are meaningful.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("ready",    32'(ReqReady),    32'(e_ready));
      check("mem_read", 32'(MemRead),     32'(e_read));
      check("mem_write",32'(MemWrite),    32'(e_write));
      check("done",     32'(Done),        32'(e_write));
      check("misalign", 32'(MisalignErr), 32'(e_err));
      if (e_addr_en) check("mem_addr_hold", MemAddr, e_addr);
      if (MemWrite) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", MemAddr, MemWData);
        end else begin
          e_item = exp_q.pop_front();
          check("write_addr", MemAddr,  e_item[63:32]);
          check("write_data", MemWData, e_item[31:0]);
        end
      end
    end
  end

  // Drives one store from its accept cycle through completion; rdly is the
  // number of cycles MemRValid is withheld after MemRead first rises.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input int rdly, input bit keep_valid);
    int kind;
    int last;
    logic [31:0] wa;
    logic [31:0] old;
    logic [31:0] nw;
    kind = classify(a, sz);
    wa   = {a[31:2], 2'b00};
    old  = mem.exists(wa) ? mem[wa] : 32'h0;
    nw   = merge_model(old, a, d, sz);
    ReqValid  = 1'b1;
    ReqAddr   = a;
    ReqData   = d;
    ReqSize   = sz;
    MemRValid = 1'($urandom_range(0, 1));
    MemRData  = $urandom;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    e_addr_en = 1'b0;
    @(posedge Clk); #1;
    if (!keep_valid) begin
      ReqValid = 1'b0;
      ReqAddr  = $urandom;
      ReqData  = $urandom;
      ReqSize  = 2'($urandom_range(0, 3));
    end
    e_addr    = wa;
    e_addr_en = 1'b1;
    if (kind != K_ERR) begin
      exp_q.push_back({wa, nw});
      mem[wa] = nw;
    end
    last = (kind == K_SUB) ? rdly + 2 : 1;
    for (int c = 1; c <= last; c++) begin
      if (kind == K_SUB && c <= rdly + 1) begin
        set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        MemRValid = (c == rdly + 1);
        MemRData  = (c == rdly + 1) ? old : $urandom;
      end else begin
        set_exp(1'b0, 1'b0, kind != K_ERR, kind == K_ERR);
        MemRValid = 1'($urandom_range(0, 1));
        MemRData  = $urandom;
      end
      @(posedge Clk); #1;
    end
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    e_addr_en = 1'b0;
    MemRValid = 1'($urandom_range(0, 1));
    MemRData  = $urandom;
  endtask

  task automatic idle_cycle();
    ReqValid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge Clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    check("rst_ready",    32'(ReqReady),    32'd1);
    check("rst_read",     32'(MemRead),     32'd0);
    check("rst_write",    32'(MemWrite),    32'd0);
    check("rst_done",     32'(Done),        32'd0);
    check("rst_misalign", 32'(MisalignErr), 32'd0);
    check("rst_addr",     MemAddr,          32'd0);
    check("rst_wdata",    MemWData,         32'd0);
    nReset = 1'b1;
    @(posedge Clk); #1;

    check("pin_byte", merge_model(32'h11223344, 32'h1003, 32'hFFFFFFAB, 2'b00), 32'hAB223344);
    check("pin_half", merge_model(32'hCAFEF00D, 32'h2002, 32'h0000BEEF, 2'b01), 32'hBEEFF00D);
    check("pin_word", merge_model(32'hDEADBEEF, 32'h3000, 32'h12345678, 2'b10), 32'h12345678);
    check("pin_half_lo", merge_model(32'h99887766, 32'h4001, 32'h12345A5A, 2'b01), 32'h99885A5A);

    mem[32'h1000] = 32'h11223344;
    mem[32'h2000] = 32'hCAFEF00D;
    mem[32'h3000] = 32'hDEADBEEF;
    mem[32'h4000] = 32'h99887766;
    mem[32'h5000] = 32'h01020304;
    mem[32'h5004] = 32'h05060708;

    chk_en = 1'b1;
    store(32'h1003, 32'hFFFFFFAB, 2'b00, 0, 1'b0);
    store(32'h2002, 32'h0000BEEF, 2'b01, 3, 1'b0);
    store(32'h3000, 32'h12345678, 2'b10, 0, 1'b0);
    store(32'h4001, 32'h12345A5A, 2'b01, 1, 1'b0);
    idle_cycle();
    for (int i = 0; i < 3; i++) store(32'h1000 + i, 32'h5A00 + i, 2'b00, i, 1'b0);
    store(32'h2000, 32'hFFFF1357, 2'b01, 0, 1'b0);
    store(32'h5003, 32'h0BADF00D, 2'b10, 0, 1'b0);
    store(32'h5004, 32'h600DCAFE, 2'b11, 0, 1'b0);
    store(32'h7000, 32'hA5A5A5A5, 2'b10, 0, 1'b1);
    store(32'h7004, 32'h5A5A5A5A, 2'b10, 0, 1'b0);
    store(32'h1001, 32'h000000EE, 2'b00, 2, 1'b1);
    store(32'h7008, 32'h0F0F0F0F, 2'b10, 0, 1'b0);
    idle_cycle();

    // Abort a sub-word store mid-read, then feed a late read response.
    chk_en    = 1'b0;
    MemRValid = 1'b0;
    ReqValid  = 1'b1;
    ReqAddr   = 32'h6001;
    ReqData   = 32'h00000077;
    ReqSize   = 2'b00;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    @(posedge Clk); #1;
    check("abort_in_read", 32'(MemRead), 32'd1);
    #2 nReset = 1'b0;
    #1;
    check("abort_ready",    32'(ReqReady),    32'd1);
    check("abort_read",     32'(MemRead),     32'd0);
    check("abort_write",    32'(MemWrite),    32'd0);
    check("abort_done",     32'(Done),        32'd0);
    check("abort_misalign", 32'(MisalignErr), 32'd0);
    check("abort_addr",     MemAddr,          32'd0);
    check("abort_wdata",    MemWData,         32'd0);
    @(posedge Clk); #1;
    nReset    = 1'b1;
    MemRValid = 1'b1;
    MemRData  = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("late_rvalid_write", 32'(MemWrite), 32'd0);
      check("late_rvalid_read",  32'(MemRead),  32'd0);
      check("late_rvalid_ready", 32'(ReqReady), 32'd1);
    end
    @(posedge Clk); #1;
    MemRValid = 1'b0;
    chk_en = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    store(32'h6001, 32'h00000077, 2'b00, 1, 1'b0);
    idle_cycle();
    idle_cycle();
    chk_en = 1'b0;

    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
